// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter that shares one serial_tx transmitter among NUM_REQ byte producers.
// Define SERIAL_TX_ARB_FIXED_PRIO_EN to select fixed priority (lowest index wins).
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for any requester; the grant is made in this state
// S_START | one-cycle start pulse to serial_tx; tick counter cleared
// S_FRAME | counting FRAME_TICKS baud ticks
// S_GAP   | counting GAP_TICKS idle baud ticks (entered only if GAP_TICKS>0)
module serial_tx_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int FRAME_TICKS = 10,
   parameter int GAP_TICKS   = 0,
   localparam int ID_W       = $clog2(NUM_REQ)
) (
   input  logic                 sysclk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req_valid_i,
   input  logic [8*NUM_REQ-1:0] req_data_i,
   output logic [NUM_REQ-1:0]   req_ready_o,
   input  logic                 baud_rate_tick_i,
   output logic                 tx_start_o,
   output logic [7:0]           tx_data_o,
   output logic                 busy_o,
   output logic [ID_W-1:0]      grant_id_o
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_FRAME = 2'd2;
   localparam logic [1:0] S_GAP   = 2'd3;

   logic [1:0]      state_q;
   logic [1:0]      state_nx;
   logic [7:0]      cnt_q;
   logic [ID_W-1:0] last_q;
   logic            found;
   logic [ID_W-1:0] winner;
   logic [7:0]      win_data;
   logic            frame_done;
   logic            gap_done;

   // Each requester gets a search distance from the last grant; the smallest valid one wins.
   always_comb begin
      int best;
      int off;
      found    = 1'b0;
      winner   = '0;
      win_data = 8'h00;
      best     = NUM_REQ;
      off      = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
`ifdef SERIAL_TX_ARB_FIXED_PRIO_EN
         off = k;
`else
         off = (k + NUM_REQ - 1 - int'(last_q)) % NUM_REQ;
`endif
         if (req_valid_i[k] && (off < best)) begin
            best     = off;
            found    = 1'b1;
            winner   = ID_W'(k);
            win_data = req_data_i[8*k +: 8];
         end
      end
   end

   assign req_ready_o = ((state_q == S_IDLE) && found) ? (NUM_REQ'(1) << winner) : '0;

   assign frame_done = baud_rate_tick_i && (cnt_q == 8'(FRAME_TICKS - 1));
   assign gap_done   = baud_rate_tick_i && (cnt_q == 8'(GAP_TICKS - 1));

   always_comb begin
      state_nx = state_q;
      case (state_q)
         S_IDLE:  if (found) state_nx = S_START;
         S_START: state_nx = S_FRAME;
         S_FRAME: if (frame_done) state_nx = (GAP_TICKS > 0) ? S_GAP : S_IDLE;
         S_GAP:   if (gap_done) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= 8'h00;
         last_q     <= ID_W'(NUM_REQ - 1);
         tx_start_o <= 1'b0;
         tx_data_o  <= 8'h00;
         busy_o     <= 1'b0;
         grant_id_o <= '0;
      end else begin
         state_q    <= state_nx;
         busy_o     <= (state_nx != S_IDLE);
         tx_start_o <= (state_q == S_IDLE) && found;
         case (state_q)
            S_IDLE: begin
               if (found) begin
                  tx_data_o  <= win_data;
                  grant_id_o <= winner;
                  last_q     <= winner;
               end
            end
            S_START: cnt_q <= 8'h00;
            // the counter restarts at zero on the FRAME->GAP hand-over
            S_FRAME: begin
               if (frame_done)             cnt_q <= 8'h00;
               else if (baud_rate_tick_i)  cnt_q <= cnt_q + 8'd1;
            end
            S_GAP: begin
               if (gap_done)               cnt_q <= 8'h00;
               else if (baud_rate_tick_i)  cnt_q <= cnt_q + 8'd1;
            end
            default: cnt_q <= 8'h00;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Bench for serial_tx_arbiter: a table of cycle vectors, directed corner sequences and
// random traffic checked against a transaction-level model (default DUT and a GAP_TICKS=2 DUT).
module tb_serial_tx_arbiter;

   localparam int N  = 4;
   localparam int FT = 10;

   logic           sysclk = 1'b0;
   logic           reset;
   logic [N-1:0]   valid;
   logic [8*N-1:0] data;
   logic           tick;

   logic [N-1:0] ready0, ready1;
   logic         start0, start1;
   logic [7:0]   txd0, txd1;
   logic         busy0, busy1;
   logic [1:0]   gid0, gid1;

   int checks   = 0;
   int failures = 0;
   bit armed    = 1'b0;

   always #5 sysclk = ~sysclk;

   serial_tx_arbiter #(.NUM_REQ(N), .FRAME_TICKS(FT), .GAP_TICKS(0)) u_dut0 (
      .sysclk(sysclk), .reset(reset), .req_valid_i(valid), .req_data_i(data),
      .req_ready_o(ready0), .baud_rate_tick_i(tick), .tx_start_o(start0),
      .tx_data_o(txd0), .busy_o(busy0), .grant_id_o(gid0));

   serial_tx_arbiter #(.NUM_REQ(N), .FRAME_TICKS(FT), .GAP_TICKS(2)) u_dut1 (
      .sysclk(sysclk), .reset(reset), .req_valid_i(valid), .req_data_i(data),
      .req_ready_o(ready1), .baud_rate_tick_i(tick), .tx_start_o(start1),
      .tx_data_o(txd1), .busy_o(busy1), .grant_id_o(gid1));

   // Model: the link is either free, or owned for a start cycle plus FT+gap counted ticks.
   typedef struct {
      bit       free;
      bit       start;
      int       left;
      int       last;
      bit [7:0] data;
      int       gid;
   } model_t;

   model_t m0, m1;

   function automatic int pick(input int last, input logic [N-1:0] v);
`ifdef SERIAL_TX_ARB_FIXED_PRIO_EN
      for (int k = 0; k < N; k++) if (v[k]) return k;
`else
      for (int d = 1; d <= N; d++) if (v[(last + d) % N]) return (last + d) % N;
`endif
      return -1;
   endfunction

   function automatic model_t mstep(input model_t m, input int gap);
      model_t n = m;
      if (reset) begin
         n.free = 1; n.start = 0; n.left = 0; n.last = N - 1; n.data = 8'h00; n.gid = 0;
      end else if (m.start) begin
         n.start = 0;
         n.left  = FT + gap;
      end else if (!m.free) begin
         if (tick) begin
            n.left = m.left - 1;
            if (n.left == 0) n.free = 1;
         end
      end else if (valid != '0) begin
         int w;
         w       = pick(m.last, valid);
         n.data  = data[8*w +: 8];
         n.gid   = w;
         n.last  = w;
         n.free  = 0;
         n.start = 1;
      end
      return n;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cmp_model(input string tag, input model_t m, input logic [N-1:0] rdy,
                            input logic st, input logic [7:0] txd, input logic bsy,
                            input logic [1:0] gid);
      logic [N-1:0] er;
      er = (m.free && valid != '0) ? N'(1 << pick(m.last, valid)) : '0;
      chk({tag, "_ready"}, 32'(rdy), 32'(er));
      chk({tag, "_start"}, 32'(st),  32'(m.start));
      chk({tag, "_data"},  32'(txd), 32'(m.data));
      chk({tag, "_busy"},  32'(bsy), 32'(!m.free));
      chk({tag, "_gid"},   32'(gid), 32'(m.gid));
   endtask

   // Drive one cycle's inputs, check both DUTs against the model, then advance the model.
   task automatic cycle(input logic r, input logic [N-1:0] v, input logic [8*N-1:0] d,
                        input logic t);
      @(negedge sysclk);
      reset = r; valid = v; data = d; tick = t;
      #1;
      if (armed) begin
         cmp_model("m0", m0, ready0, start0, txd0, busy0, gid0);
         cmp_model("m1", m1, ready1, start1, txd1, busy1, gid1);
      end
      m0 = mstep(m0, 0);
      m1 = mstep(m1, 2);
      if (r) armed = 1'b1;
   endtask

   typedef struct {
      logic         r;
      logic [N-1:0] v;
      logic [7:0]   d0;
      logic         t;
      logic [N-1:0] e_ready;
      logic         e_start;
      logic [7:0]   e_data;
      logic         e_busy;
   } vec_t;

   vec_t tbl[16];

   initial begin
      int exp_rr[5];
      int n_st, last0, last1, fp_n, fp_exp;

      reset = 1'b1; valid = '0; data = '0; tick = 1'b0;

      // requester 0 alone, tick every cycle including the START cycle
      tbl[0]  = '{1'b1, 4'b0000, 8'h00, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0};
      tbl[1]  = '{1'b0, 4'b0000, 8'h00, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0};
      tbl[2]  = '{1'b0, 4'b0001, 8'hA5, 1'b1, 4'b0001, 1'b0, 8'h00, 1'b0};
      tbl[3]  = '{1'b0, 4'b0000, 8'h00, 1'b1, 4'b0000, 1'b1, 8'hA5, 1'b1};
      for (int i = 4; i <= 13; i++)
         tbl[i] = '{1'b0, 4'b0000, 8'h00, 1'b1, 4'b0000, 1'b0, 8'hA5, 1'b1};
      tbl[14] = '{1'b0, 4'b0001, 8'h5A, 1'b0, 4'b0001, 1'b0, 8'hA5, 1'b0};
      tbl[15] = '{1'b0, 4'b0000, 8'h00, 1'b0, 4'b0000, 1'b1, 8'h5A, 1'b1};

      for (int i = 0; i < 16; i++) begin
         cycle(tbl[i].r, tbl[i].v, {24'h0, tbl[i].d0}, tbl[i].t);
         if (i > 0) begin
            chk($sformatf("vec%0d_ready", i), 32'(ready0), 32'(tbl[i].e_ready));
            chk($sformatf("vec%0d_start", i), 32'(start0), 32'(tbl[i].e_start));
            chk($sformatf("vec%0d_data", i),  32'(txd0),   32'(tbl[i].e_data));
            chk($sformatf("vec%0d_busy", i),  32'(busy0),  32'(tbl[i].e_busy));
         end
      end

      // all four requesters continuously valid
`ifdef SERIAL_TX_ARB_FIXED_PRIO_EN
      exp_rr = '{0, 0, 0, 0, 0};
`else
      exp_rr = '{0, 1, 2, 3, 0};
`endif
      cycle(1'b1, '0, '0, 1'b0);
      n_st = 0; last0 = -1; last1 = -1;
      for (int c = 0; c < 120 && n_st < 5; c++) begin
         cycle(1'b0, 4'hF, 32'h13121110, 1'b1);
         if (start0) begin
            chk("rr_gid", 32'(gid0), 32'(exp_rr[n_st]));
            chk("rr_data", 32'(txd0), 32'(8'h10 + exp_rr[n_st]));
            if (n_st > 0) chk("rr_spacing", 32'(c - last0), 32'd12);
            last0 = c;
            n_st++;
         end
         if (start1) begin
            if (last1 >= 0) chk("gap_spacing", 32'(c - last1), 32'd14);
            last1 = c;
         end
      end
      chk("rr_count", 32'(n_st), 32'd5);

      // reset coinciding with the 5th tick of a frame
      cycle(1'b1, '0, '0, 1'b0);
      cycle(1'b0, 4'b0001, 32'h000000A5, 1'b0);
      cycle(1'b0, 4'b0000, '0, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 4'b0000, '0, 1'b1);
      cycle(1'b1, 4'b0000, '0, 1'b1);
      cycle(1'b0, 4'b1111, 32'h44332211, 1'b0);
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_start", 32'(start0), 32'd0);
      chk("rst_data", 32'(txd0), 32'd0);
      chk("rst_gid", 32'(gid0), 32'd0);
      chk("rst_ready0", 32'(ready0), 32'b0001);
      chk("rst_ready1", 32'(ready1), 32'b0001);

      // requesters 1 and 3 continuously valid
      cycle(1'b1, '0, '0, 1'b0);
      fp_n = 0;
      for (int c = 0; c < 60; c++) begin
         cycle(1'b0, 4'b1010, 32'h33002200, 1'b1);
         if (start0) begin
`ifdef SERIAL_TX_ARB_FIXED_PRIO_EN
            fp_exp = 1;
`else
            fp_exp = (fp_n % 2 == 0) ? 1 : 3;
`endif
            chk("fp_gid", 32'(gid0), 32'(fp_exp));
            fp_n++;
         end
      end
      chk("fp_count_ok", 32'(fp_n >= 3), 32'd1);

      // random traffic against the model
      cycle(1'b1, '0, '0, 1'b0);
      for (int c = 0; c < 3000; c++) begin
         cycle(($urandom_range(0, 199) == 0), N'($urandom), $urandom, ($urandom_range(0, 2) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
